// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: fetches instruction words, decodes operand fields and presents them under valid/ready.
module instr_fetch_decode #(
  parameter int ADDR_W = 8,
  parameter int MAX_OPCODE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode,
  output logic [4:0]        rdst2,
  output logic [4:0]        rdst1,
  output logic [4:0]        rsrc2,
  output logic [4:0]        rsrc1,
  output logic [15:0]       imm,
  output logic [7:0]        rsrc_add,
  output logic [7:0]        rdst_add,
  output logic [ADDR_W-1:0] out_pc,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc
);
  typedef enum logic [2:0] {IDLE, REQ, RESP, OUT, HALT} state_t;
  state_t state, state_nxt;
  logic [5:0] op;
  logic legal, rtype;
  logic [4:0] d_rdst2, d_rdst1, d_rsrc2, d_rsrc1;
  logic [15:0] d_imm;
  logic [7:0] d_rsrc_add, d_rdst_add;
  assign op = imem_rdata[31:26];
  assign legal = op <= 6'(MAX_OPCODE);
  assign rtype = op >= 6'd4;
  assign imem_en = state == REQ;
  assign imem_addr = (state == REQ) ? pc : '0;
  // Unused fields of each format decode to zero.
  always_comb begin
    d_rdst2 = (op != 6'd3) ? imem_rdata[25:21] : '0;
    d_rdst1 = rtype ? imem_rdata[20:16] : '0;
    d_rsrc2 = (op == 6'd1 || op == 6'd3) ? imem_rdata[4:0] : rtype ? imem_rdata[9:5] : '0;
    d_rsrc1 = rtype ? imem_rdata[4:0] : '0;
    d_imm = (op == 6'd0) ? imem_rdata[15:0] : '0;
    d_rsrc_add = (op == 6'd2) ? imem_rdata[7:0] : '0;
    d_rdst_add = (op == 6'd3) ? imem_rdata[25:18] : '0;
  end
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = enable ? REQ : IDLE;
      REQ: state_nxt = RESP;
      RESP: state_nxt = legal ? OUT : HALT;
      OUT: state_nxt = out_ready ? (enable ? REQ : IDLE) : OUT;
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
    if (pc_load) state_nxt = enable ? REQ : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
      out_valid <= 1'b0;
      illegal <= 1'b0;
      out_pc <= '0;
      opcode <= '0;
      rdst2 <= '0;
      rdst1 <= '0;
      rsrc2 <= '0;
      rsrc1 <= '0;
      imm <= '0;
      rsrc_add <= '0;
      rdst_add <= '0;
    end else if (pc_load) begin
      pc <= pc_load_value;
      illegal <= 1'b0;
      out_valid <= 1'b0;
    end else if (state == RESP) begin
      if (legal) begin
        opcode <= op;
        rdst2 <= d_rdst2;
        rdst1 <= d_rdst1;
        rsrc2 <= d_rsrc2;
        rsrc1 <= d_rsrc1;
        imm <= d_imm;
        rsrc_add <= d_rsrc_add;
        rdst_add <= d_rdst_add;
        out_pc <= pc;
        pc <= pc + ADDR_W'(1);
        out_valid <= 1'b1;
      end else illegal <= 1'b1;
    end else if (state == OUT && out_ready) out_valid <= 1'b0;
  end
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: directed scoreboard bench for instr_fetch_decode.
module tb_instr_fetch_decode;
  logic clk, rst_n, enable, pc_load, imem_en, out_valid, out_ready, illegal;
  logic [7:0] pc_load_value, imem_addr, out_pc, pc, rsrc_add, rdst_add;
  logic [31:0] imem_rdata;
  logic [5:0] opcode;
  logic [4:0] rdst2, rdst1, rsrc2, rsrc1;
  logic [15:0] imm;
  logic [31:0] mem [256];
  int passed = 0, total = 0;
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rd2, rd1, rs2, rs1;
    logic [15:0] imm;
    logic [7:0] sa, da, opc;
  } exp_t;
  exp_t q[$];

  instr_fetch_decode dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .rdst2(rdst2), .rdst1(rdst1), .rsrc2(rsrc2),
    .rsrc1(rsrc1), .imm(imm), .rsrc_add(rsrc_add), .rdst_add(rdst_add), .out_pc(out_pc),
    .illegal(illegal), .pc(pc)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [5:0] op, input logic [4:0] rd2, rd1, rs2, rs1,
                      input logic [15:0] im, input logic [7:0] sa, da, opc);
    q.push_back('{op, rd2, rd1, rs2, rs1, im, sa, da, opc});
  endtask

  task automatic check_out();
    exp_t e;
    chk("sb_depth", 32'(q.size()), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("opcode", opcode, e.op);
      chk("rdst2", rdst2, e.rd2);
      chk("rdst1", rdst1, e.rd1);
      chk("rsrc2", rsrc2, e.rs2);
      chk("rsrc1", rsrc1, e.rs1);
      chk("imm", imm, e.imm);
      chk("rsrc_add", rsrc_add, e.sa);
      chk("rdst_add", rdst_add, e.da);
      chk("out_pc", out_pc, e.opc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 32'h0060_1234;
    mem[1] = 32'h1085_20C5;
    mem[8'h40] = 32'h04EF_FFFA;
    mem[8'h41] = 32'h0BFF_FFA5;
    mem[8'hFF] = 32'h0E73_FFF1;
    mem[8'h10] = 32'h4022_FC64;
    imem_rdata = '0;
    rst_n = 0; enable = 0; pc_load = 0; pc_load_value = 0; out_ready = 0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_imem_en", imem_en, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_out_pc", out_pc, 0);
    // First fetch: opcode 0 at address 0
    rst_n = 1; enable = 1;
    push(0, 3, 0, 0, 0, 16'h1234, 0, 0, 0);
    tick();
    chk("req0_en", imem_en, 1);
    chk("req0_addr", imem_addr, 0);
    tick();
    chk("resp0_valid", out_valid, 0);
    tick();
    chk("out0_valid", out_valid, 1);
    chk("out0_pc", pc, 1);
    check_out();
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("hs0_valid", out_valid, 0);
    chk("req1_en", imem_en, 1);
    chk("req1_addr", imem_addr, 1);
    // R-type held under backpressure
    push(4, 4, 5, 6, 5, 0, 0, 0, 1);
    tick(); tick();
    chk("out1_valid", out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_en", imem_en, 0);
      chk("stall_rsrc2", rsrc2, 6);
    end
    check_out();
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("req2_en", imem_en, 1);
    chk("req2_addr", imem_addr, 2);
    // Redirect during RESP discards the fetched word
    tick();
    pc_load = 1; pc_load_value = 8'h40;
    tick();
    pc_load = 0;
    chk("redir_valid", out_valid, 0);
    chk("redir_pc", pc, 8'h40);
    chk("redir_en", imem_en, 1);
    chk("redir_addr", imem_addr, 8'h40);
    push(1, 7, 0, 5'h1A, 0, 0, 0, 0, 8'h40);
    tick(); tick();
    chk("out40_valid", out_valid, 1);
    chk("out40_pc", pc, 8'h41);
    check_out();
    out_ready = 1;
    tick();
    out_ready = 0; enable = 0;
    chk("req41_addr", imem_addr, 8'h41);
    // enable low does not abort the fetch already issued
    push(2, 5'h1F, 0, 0, 0, 0, 8'hA5, 0, 8'h41);
    tick(); tick();
    chk("out41_valid", out_valid, 1);
    check_out();
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("idle_valid", out_valid, 0);
    tick();
    chk("idle_en", imem_en, 0);
    // Wrap: fetch at 255, next fetch at 0
    pc_load = 1; pc_load_value = 8'hFF; enable = 1;
    tick();
    pc_load = 0;
    chk("reqff_addr", imem_addr, 8'hFF);
    push(3, 0, 0, 5'h11, 0, 0, 0, 8'h9C, 8'hFF);
    tick(); tick();
    chk("wrap_pc", pc, 0);
    check_out();
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("wrap_en", imem_en, 1);
    chk("wrap_addr", imem_addr, 0);
    // Illegal opcode 17 halts
    mem[0] = 32'h4400_0000;
    tick(); tick();
    chk("halt_illegal", illegal, 1);
    chk("halt_valid", out_valid, 0);
    chk("halt_pc", pc, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_en", imem_en, 0);
      chk("halt_valid_hold", out_valid, 0);
    end
    pc_load = 1; pc_load_value = 8'h10;
    tick();
    pc_load = 0;
    chk("resume_illegal", illegal, 0);
    chk("resume_en", imem_en, 1);
    chk("resume_addr", imem_addr, 8'h10);
    push(6'd16, 1, 2, 3, 4, 0, 0, 0, 8'h10);
    tick(); tick();
    chk("out10_valid", out_valid, 1);
    check_out();
    // Asynchronous reset while presenting
    #2 rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_pc", pc, 0);
    chk("arst_opcode", opcode, 0);
    chk("arst_out_pc", out_pc, 0);
    tick();
    rst_n = 1; enable = 0;
    tick();
    chk("arst_idle_en", imem_en, 0);
    chk("sb_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
